// File: rtl/sd_blk_pkg.sv
// Shared types and the round-robin picker for the block-device arbiter.
package sd_blk_pkg;

    localparam int unsigned MAX_CH = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        FIN
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } pick_t;

    // First set bit of pend at or above ptr, wrapping at n; ptr must be < n.
    function automatic pick_t rr_pick(
        input logic [MAX_CH-1:0] pend,
        input logic [2:0]        ptr,
        input logic [3:0]        n
    );
        pick_t      r;
        logic [3:0] idx;
        r = '0;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (!r.valid && (4'(k) < n) && pend[idx[2:0]]) begin
                r.valid = 1'b1;
                r.idx   = idx[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sd_blk_arbiter_if.sv
// hps_io side of the block-device handshake, one bit/slice per channel.
interface sd_blk_arbiter_if #(
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned LBA_W  = 32
);
    logic [NUM_CH*LBA_W-1:0] sd_lba;
    logic [NUM_CH-1:0]       sd_rd;
    logic [NUM_CH-1:0]       sd_wr;
    logic [NUM_CH-1:0]       sd_ack;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        output sd_ack
    );
endinterface

// File: rtl/sd_blk_chan.sv
// Per-channel state: mount/protect flags, pending bits, LBA latch and err pulse.
module sd_blk_chan #(
    parameter int unsigned LBA_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_rd,
    input  logic             req_wr,
    input  logic [LBA_W-1:0] req_lba,
    input  logic             img_mounted,
    input  logic             img_readonly,
    input  logic             img_size_nz,
    input  logic             grant_rd,
    input  logic             grant_wr,
    input  logic             active,
    input  logic             timeout,
    output logic             pend_rd,
    output logic             pend_wr,
    output logic [LBA_W-1:0] lba,
    output logic             mounted,
    output logic             protect,
    output logic             err
);
    logic acc_rd;
    logic acc_wr;
    logic reject;

    always_comb begin
        acc_rd = req_rd & mounted;
        acc_wr = req_wr & mounted & ~protect;
        reject = (req_rd & ~acc_rd) | (req_wr & ~acc_wr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_rd <= 1'b0;
            pend_wr <= 1'b0;
            lba     <= '0;
            mounted <= 1'b0;
            protect <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (req_rd || req_wr) begin
                lba <= req_lba;
            end
            if (img_mounted) begin
                mounted <= img_size_nz;
                protect <= img_readonly;
                pend_rd <= 1'b0;
                pend_wr <= 1'b0;
            end else begin
                // A new request beats the grant clear so it survives as a fresh operation.
                pend_rd <= (pend_rd & ~grant_rd) | acc_rd;
                pend_wr <= (pend_wr & ~grant_wr) | acc_wr;
            end
            err <= reject | (img_mounted & active) | timeout;
        end
    end
endmodule

// File: rtl/sd_blk_arbiter.sv
// Round-robin arbiter sharing the hps_io sd_rd/sd_wr/sd_ack handshake among NUM_CH block devices.
module sd_blk_arbiter #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned LBA_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       req_rd,
    input  logic [NUM_CH-1:0]       req_wr,
    input  logic [NUM_CH*LBA_W-1:0] req_lba,
    input  logic [NUM_CH-1:0]       img_mounted,
    input  logic                    img_readonly,
    input  logic                    img_size_nz,
    sd_blk_arbiter_if.master        sd,
    output logic [NUM_CH-1:0]       mounted,
    output logic [NUM_CH-1:0]       protect,
    output logic [NUM_CH-1:0]       cpu_wait,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       err
);
    import sd_blk_pkg::*;

    localparam int unsigned      CNT_W    = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    state_t                  state;
    logic [2:0]              g;
    logic [2:0]              rr_ptr;
    logic [CNT_W-1:0]        cnt;
    logic [NUM_CH-1:0]       rd_q;
    logic [NUM_CH-1:0]       wr_q;
    logic [NUM_CH-1:0]       ack_q;
    logic [NUM_CH-1:0]       pend_rd;
    logic [NUM_CH-1:0]       pend_wr;
    logic [NUM_CH-1:0]       gsel;
    logic [NUM_CH-1:0]       pick_oh;
    logic [NUM_CH-1:0]       grant_rd;
    logic [NUM_CH-1:0]       grant_wr;
    logic [NUM_CH-1:0]       active;
    logic [NUM_CH-1:0]       timeout;
    logic [NUM_CH*LBA_W-1:0] lba_flat;
    pick_t                   pick;
    logic                    grant_go;
    logic                    ack_cur;
    logic                    ack_old;
    logic                    ack_rise;
    logic                    ack_fall;
    logic                    abort;
    logic                    timeout_hit;

    always_comb begin
        gsel     = NUM_CH'(1) << g;
        // Channels being (re)mounted this cycle lose their pending bits, so never grant them.
        pick     = rr_pick(MAX_CH'((pend_rd | pend_wr) & ~img_mounted), rr_ptr, 4'(NUM_CH));
        pick_oh  = NUM_CH'(1) << pick.idx;
        grant_go = (state == IDLE) && pick.valid;
        grant_rd = grant_go ? (pick_oh & pend_rd) : '0;
        grant_wr = (grant_go && (grant_rd == '0)) ? (pick_oh & pend_wr) : '0;
        ack_cur  = |(sd.sd_ack & gsel);
        ack_old  = |(ack_q & gsel);
        ack_rise = ack_cur & ~ack_old;
        ack_fall = ~ack_cur & ack_old;
        active   = (state != IDLE) ? gsel : '0;
        abort    = |(img_mounted & active);
        timeout_hit = (TIMEOUT_CYC != 0) && (state == REQ) && !ack_rise && !abort
                      && (cnt == CNT_LAST);
        timeout  = timeout_hit ? gsel : '0;
        cpu_wait = pend_rd | pend_wr | active;
    end

    assign sd.sd_rd  = rd_q;
    assign sd.sd_wr  = wr_q;
    assign sd.sd_lba = lba_flat;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state  <= IDLE;
            g      <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
            rd_q   <= '0;
            wr_q   <= '0;
            ack_q  <= '0;
            done   <= '0;
        end else begin
            ack_q <= sd.sd_ack;
            done  <= '0;
            if (abort) begin
                state <= IDLE;
                rd_q  <= '0;
                wr_q  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (grant_go) begin
                            g     <= pick.idx;
                            cnt   <= '0;
                            state <= REQ;
                            if (grant_rd != '0) begin
                                rd_q <= pick_oh;
                            end else begin
                                wr_q <= pick_oh;
                            end
                        end
                    end
                    REQ: begin
                        if (ack_rise) begin
                            rd_q  <= '0;
                            wr_q  <= '0;
                            state <= XFER;
                        end else if (timeout_hit) begin
                            rd_q  <= '0;
                            wr_q  <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    XFER: begin
                        if (ack_fall) begin
                            state <= FIN;
                        end
                    end
                    FIN: begin
                        done   <= gsel;
                        rr_ptr <= (g == 3'(NUM_CH - 1)) ? 3'd0 : g + 3'd1;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        sd_blk_chan #(
            .LBA_W(LBA_W)
        ) u_chan (
            .clk          (clk_sys),
            .reset        (reset),
            .req_rd       (req_rd[i]),
            .req_wr       (req_wr[i]),
            .req_lba      (req_lba[i*LBA_W +: LBA_W]),
            .img_mounted  (img_mounted[i]),
            .img_readonly (img_readonly),
            .img_size_nz  (img_size_nz),
            .grant_rd     (grant_rd[i]),
            .grant_wr     (grant_wr[i]),
            .active       (active[i]),
            .timeout      (timeout[i]),
            .pend_rd      (pend_rd[i]),
            .pend_wr      (pend_wr[i]),
            .lba          (lba_flat[i*LBA_W +: LBA_W]),
            .mounted      (mounted[i]),
            .protect      (protect[i]),
            .err          (err[i])
        );
    end
endmodule

// File: tb/tb_sd_blk_arbiter.sv
// Directed bench for sd_blk_arbiter: three channels, 16-cycle ack timeout.
module tb_sd_blk_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_rd;
    logic [2:0]  req_wr;
    logic [95:0] req_lba;
    logic [2:0]  img_mounted;
    logic        img_readonly;
    logic        img_size_nz;
    logic [2:0]  mounted;
    logic [2:0]  protect;
    logic [2:0]  cpu_wait;
    logic [2:0]  done;
    logic [2:0]  err;

    int total = 0;
    int bad = 0;
    int done0_cnt = 0;
    int d0;

    sd_blk_arbiter_if #(.NUM_CH(3), .LBA_W(32)) sd ();

    sd_blk_arbiter #(
        .NUM_CH      (3),
        .LBA_W       (32),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk_sys      (clk),
        .reset        (reset),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .img_mounted  (img_mounted),
        .img_readonly (img_readonly),
        .img_size_nz  (img_size_nz),
        .sd           (sd.master),
        .mounted      (mounted),
        .protect      (protect),
        .cpu_wait     (cpu_wait),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done[0] === 1'b1) done0_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the grant, checks it, runs a 3-cycle ack and checks the done pulse.
    task automatic serve(input string tag, input int unsigned ch, input logic is_wr);
        logic [2:0]  oh;
        int unsigned n;
        oh = 3'b001 << ch;
        n = 0;
        while (((sd.sd_rd | sd.sd_wr) == 3'b000) && (n < 40)) begin
            step();
            n++;
        end
        chk({tag, "_grant_in_time"}, 128'(n < 40), 128'(1));
        chk({tag, "_rd"}, 128'(sd.sd_rd), is_wr ? 128'(0) : 128'(oh));
        chk({tag, "_wr"}, 128'(sd.sd_wr), is_wr ? 128'(oh) : 128'(0));
        sd.sd_ack = oh;
        step();
        chk({tag, "_req_drop"}, 128'(sd.sd_rd | sd.sd_wr), 128'(0));
        step();
        step();
        sd.sd_ack = 3'b000;
        n = 0;
        while ((done == 3'b000) && (n < 10)) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 128'(done), 128'(oh));
    endtask

    initial begin
        reset        = 1'b1;
        req_rd       = '0;
        req_wr       = '0;
        req_lba      = '0;
        img_mounted  = '0;
        img_readonly = 1'b0;
        img_size_nz  = 1'b0;
        sd.sd_ack    = '0;
        step();
        step();
        chk("rst_sd_rd", 128'(sd.sd_rd), 128'(0));
        chk("rst_sd_wr", 128'(sd.sd_wr), 128'(0));
        chk("rst_lba", 128'(sd.sd_lba), 128'(0));
        chk("rst_outs", 128'({mounted, protect, cpu_wait, done, err}), 128'(0));
        reset = 1'b0;

        // ch0 writable image, ch1 readonly image, ch2 left empty
        img_mounted = 3'b001; img_size_nz = 1'b1; img_readonly = 1'b0;
        step();
        img_mounted = 3'b010; img_readonly = 1'b1;
        step();
        img_mounted = 3'b000; img_readonly = 1'b0;
        chk("mnt_mounted", 128'(mounted), 128'(3'b011));
        chk("mnt_protect", 128'(protect), 128'(3'b010));

        // single read on ch0
        req_rd = 3'b001; req_lba[31:0] = 32'h0000_1234;
        step();
        req_rd = 3'b000;
        chk("t1_lba", 128'(sd.sd_lba[31:0]), 128'(32'h0000_1234));
        chk("t1_rd_not_yet", 128'(sd.sd_rd), 128'(0));
        chk("t1_wait_pend", 128'(cpu_wait), 128'(3'b001));
        step();
        chk("t1_rd_lat2", 128'(sd.sd_rd), 128'(3'b001));
        sd.sd_ack = 3'b001;
        step();
        chk("t1_rd_drop", 128'(sd.sd_rd), 128'(0));
        step();
        step();
        sd.sd_ack = 3'b000;
        chk("t1_wait_xfer", 128'(cpu_wait), 128'(3'b001));
        step();
        chk("t1_done_early", 128'(done), 128'(0));
        step();
        chk("t1_done", 128'(done), 128'(3'b001));
        chk("t1_wait_clear", 128'(cpu_wait), 128'(0));
        step();
        chk("t1_done_once", 128'(done), 128'(0));

        // rejections: write on readonly ch1, read on empty ch2
        req_wr = 3'b010; req_lba[63:32] = 32'h0000_BEEF;
        step();
        req_wr = 3'b000;
        chk("t2_err1", 128'(err), 128'(3'b010));
        chk("t2_lba1", 128'(sd.sd_lba[63:32]), 128'(32'h0000_BEEF));
        chk("t2_wait1", 128'(cpu_wait), 128'(0));
        step();
        chk("t2_err1_off", 128'(err), 128'(0));
        chk("t2_no_wr", 128'(sd.sd_wr), 128'(0));
        req_rd = 3'b100;
        step();
        req_rd = 3'b000;
        chk("t2_err2", 128'(err), 128'(3'b100));
        chk("t2_wait2", 128'(cpu_wait), 128'(0));
        step();
        chk("t2_no_rd", 128'(sd.sd_rd), 128'(0));

        // mount ch2 and serve it once so the RR pointer wraps back to 0
        img_mounted = 3'b100; img_size_nz = 1'b1;
        step();
        img_mounted = 3'b000;
        req_rd = 3'b100; req_lba[95:64] = 32'h0000_0077;
        step();
        req_rd = 3'b000;
        serve("t3_pre2", 2, 1'b0);

        // all three in one cycle; ch0 re-requests while ch1 is granted
        req_rd = 3'b111;
        step();
        req_rd = 3'b000;
        serve("t3_a0", 0, 1'b0);
        req_rd = 3'b001;
        step();
        req_rd = 3'b000;
        serve("t3_b1", 1, 1'b0);
        serve("t3_c2", 2, 1'b0);
        serve("t3_d0", 0, 1'b0);
        step();
        chk("t3_idle", 128'(cpu_wait), 128'(0));

        // read and write pulsed together on ch0: read first, then write
        d0 = done0_cnt;
        req_rd = 3'b001; req_wr = 3'b001; req_lba[31:0] = 32'h00AB_CDEF;
        step();
        req_rd = 3'b000; req_wr = 3'b000;
        chk("t4_lba", 128'(sd.sd_lba[31:0]), 128'(32'h00AB_CDEF));
        serve("t4_rd", 0, 1'b0);
        serve("t4_wr", 0, 1'b1);
        step();
        step();
        chk("t4_two_done", 128'(done0_cnt - d0), 128'(2));
        chk("t4_idle", 128'(cpu_wait), 128'(0));

        // no ack on ch0: aborted after 16 REQ cycles, then pending ch1 granted
        req_rd = 3'b001;
        step();
        req_rd = 3'b000;
        step();
        chk("t5_rd_on", 128'(sd.sd_rd), 128'(3'b001));
        req_rd = 3'b010;
        step();
        req_rd = 3'b000;
        for (int k = 0; k < 14; k++) step();
        chk("t5_rd_cyc16", 128'(sd.sd_rd), 128'(3'b001));
        chk("t5_no_err_yet", 128'(err), 128'(0));
        step();
        chk("t5_rd_drop", 128'(sd.sd_rd), 128'(0));
        chk("t5_err", 128'(err), 128'(3'b001));
        chk("t5_wait", 128'(cpu_wait), 128'(3'b010));
        step();
        chk("t5_next_grant", 128'(sd.sd_rd), 128'(3'b010));
        chk("t5_err_off", 128'(err), 128'(0));
        serve("t5_ch1", 1, 1'b0);

        // reset while ch0 is in XFER with ch2 pending
        d0 = done0_cnt;
        req_rd = 3'b001;
        step();
        req_rd = 3'b000;
        step();
        sd.sd_ack = 3'b001; req_rd = 3'b100;
        step();
        req_rd = 3'b000;
        chk("t6_xfer_wait", 128'(cpu_wait), 128'(3'b101));
        reset = 1'b1;
        step();
        chk("t6_rst_req", 128'(sd.sd_rd | sd.sd_wr), 128'(0));
        chk("t6_rst_outs", 128'({cpu_wait, done, err}), 128'(0));
        reset = 1'b0;
        sd.sd_ack = 3'b000;
        step();
        step();
        step();
        chk("t6_no_done", 128'(done0_cnt - d0), 128'(0));
        chk("t6_quiet", 128'({sd.sd_rd, sd.sd_wr, err}), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
